// File: rtl/mem_xfer_engine_if.sv
// rtl/mem_xfer_engine_if.sv - command/status and memory bus bundle for the transfer engine
interface mem_xfer_engine_if #(
   parameter int W = 8,
   parameter int A = 8
);
   // command and status
   logic         start;
   logic [A-1:0] src_addr;
   logic [A-1:0] dst_addr;
   logic [A-1:0] len;
   logic [W-1:0] key;
   logic         busy;
   logic         done;
   // single-port data memory
   logic [A-1:0] mem_addr;
   logic         mem_we;
   logic [W-1:0] mem_wdata;
   logic [W-1:0] mem_rdata;

   // engine side: accepts commands, initiates memory accesses
   modport master (
      input  start, src_addr, dst_addr, len, key, mem_rdata,
      output busy, done, mem_addr, mem_we, mem_wdata
   );

   // environment side: issues commands, hosts the memory
   modport slave (
      output start, src_addr, dst_addr, len, key, mem_rdata,
      input  busy, done, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_xfer_engine.sv
// rtl/mem_xfer_engine.sv - byte copy engine with XOR mask, one memory access per cycle
module mem_xfer_engine #(
   parameter int W = 8,
   parameter int A = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   mem_xfer_engine_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic [A-1:0] src_q, src_d;
   logic [A-1:0] dst_q, dst_d;
   logic [A-1:0] cnt_q, cnt_d;
   logic [W-1:0] key_q, key_d;
   logic [W-1:0] buf_q, buf_d;

   // state and datapath registers; reset aborts any transfer in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         key_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         buf_q   <= buf_d;
      end
   end

   // next state: latch the command in IDLE, then alternate read/write until the count runs out
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               src_d   = bus.src_addr;
               dst_d   = bus.dst_addr;
               cnt_d   = bus.len;
               key_d   = bus.key;
               state_d = (bus.len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            buf_d   = bus.mem_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            // pointers wrap naturally at 2**A
            src_d   = src_q + A'(1);
            dst_d   = dst_q + A'(1);
            cnt_d   = cnt_q - A'(1);
            state_d = (cnt_q == A'(1)) ? S_DONE : S_READ;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from state and registers only, so reset clears them immediately
   always_comb begin
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      case (state_q)
         S_READ: begin
            bus.busy     = 1'b1;
            bus.mem_addr = src_q;
         end
         S_WRITE: begin
            bus.busy      = 1'b1;
            bus.mem_addr  = dst_q;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = buf_q ^ key_q;
         end
         S_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// tb/tb_mem_xfer_engine.sv - directed self-checking bench for mem_xfer_engine
module tb_mem_xfer_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mem_xfer_engine_if #(.W(8), .A(8)) bus ();

   mem_xfer_engine #(.W(8), .A(8)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // behavioural data memory with a bench-side preload port
   logic [7:0] mem [256];
   logic       tb_we = 1'b0;
   logic [7:0] tb_addr = 8'h00;
   logic [7:0] tb_wd = 8'h00;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (tb_we)
         mem[tb_addr] <= tb_wd;
      else if (bus.mem_we)
         mem[bus.mem_addr] <= bus.mem_wdata;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // call at a negedge; returns at the next negedge
   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      tb_addr = a;
      tb_wd   = d;
      tb_we   = 1'b1;
      @(negedge clk);
      tb_we   = 1'b0;
   endtask

   logic [15:0] busy_m, done_m, we_m;

   // launch at a negedge, then log status for cycles 1..ncyc (cycle k follows edge k-1)
   task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input logic [7:0] k, input int ncyc, input bit inject);
      busy_m = '0;
      done_m = '0;
      we_m   = '0;
      bus.src_addr = s;
      bus.dst_addr = d;
      bus.len      = l;
      bus.key      = k;
      bus.start    = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         busy_m[c] = bus.busy;
         done_m[c] = bus.done;
         we_m[c]   = bus.mem_we;
         if (inject && c == 4) begin
            bus.start    = 1'b1;
            bus.src_addr = 8'h90;
            bus.dst_addr = 8'h60;
            bus.len      = 8'h05;
         end
         if (inject && c == 5)
            bus.start = 1'b0;
      end
   endtask

   task automatic load_plain();
      poke(8'h10, 8'h11);
      poke(8'h11, 8'h22);
      poke(8'h12, 8'h33);
      poke(8'h13, 8'h44);
      for (int i = 0; i < 4; i++) poke(8'h40 + 8'(i), 8'h00);
   endtask

   task automatic check_plain(input string tag);
      check({tag, "_m40"}, {24'h0, mem[8'h40]}, 32'h11);
      check({tag, "_m41"}, {24'h0, mem[8'h41]}, 32'h22);
      check({tag, "_m42"}, {24'h0, mem[8'h42]}, 32'h33);
      check({tag, "_m43"}, {24'h0, mem[8'h43]}, 32'h44);
      check({tag, "_busy"}, {16'h0, busy_m}, 32'h03FE);
      check({tag, "_done"}, {16'h0, done_m}, 32'h0200);
      check({tag, "_we"},   {16'h0, we_m},   32'h0154);
      check({tag, "_nwr"},  $countones(we_m), 32'd4);
   endtask

   logic we_seen;

   initial begin
      bus.start    = 1'b0;
      bus.src_addr = 8'h00;
      bus.dst_addr = 8'h00;
      bus.len      = 8'h00;
      bus.key      = 8'h00;

      // reset state
      #1;
      check("rst_busy",  {31'h0, bus.busy},   32'h0);
      check("rst_done",  {31'h0, bus.done},   32'h0);
      check("rst_we",    {31'h0, bus.mem_we}, 32'h0);
      check("rst_addr",  {24'h0, bus.mem_addr},  32'h0);
      check("rst_wdata", {24'h0, bus.mem_wdata}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      we_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         we_seen = we_seen | bus.mem_we;
      end
      check("idle_we", {31'h0, we_seen}, 32'h0);

      // plain copy
      load_plain();
      run_xfer(8'h10, 8'h40, 8'd4, 8'h00, 11, 1'b0);
      check_plain("copy");

      // XOR with source wrap
      poke(8'hFE, 8'h00);
      poke(8'hFF, 8'hA5);
      poke(8'h00, 8'h3C);
      run_xfer(8'hFE, 8'h80, 8'd3, 8'h5A, 8, 1'b0);
      check("xor_m80", {24'h0, mem[8'h80]}, 32'h5A);
      check("xor_m81", {24'h0, mem[8'h81]}, 32'hFF);
      check("xor_m82", {24'h0, mem[8'h82]}, 32'h66);

      // forward overlap replicates the first byte
      poke(8'h20, 8'hA5);
      poke(8'h21, 8'h00);
      poke(8'h22, 8'h00);
      poke(8'h23, 8'h00);
      run_xfer(8'h20, 8'h21, 8'd3, 8'h00, 8, 1'b0);
      check("ovl_m21", {24'h0, mem[8'h21]}, 32'hA5);
      check("ovl_m22", {24'h0, mem[8'h22]}, 32'hA5);
      check("ovl_m23", {24'h0, mem[8'h23]}, 32'hA5);

      // Len = 0
      run_xfer(8'h10, 8'h40, 8'd0, 8'h00, 3, 1'b0);
      check("len0_busy", {16'h0, busy_m}, 32'h0002);
      check("len0_done", {16'h0, done_m}, 32'h0002);
      check("len0_we",   {16'h0, we_m},   32'h0000);

      // Start while busy is ignored
      load_plain();
      poke(8'h60, 8'h00);
      run_xfer(8'h10, 8'h40, 8'd4, 8'h00, 11, 1'b1);
      check_plain("busy_start");
      check("busy_start_m60", {24'h0, mem[8'h60]}, 32'h00);

      // async abort during the second WRITE
      load_plain();
      bus.src_addr = 8'h10;
      bus.dst_addr = 8'h40;
      bus.len      = 8'd4;
      bus.key      = 8'h00;
      bus.start    = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_we_pre", {31'h0, bus.mem_we}, 32'h1);
      check("abort_addr_pre", {24'h0, bus.mem_addr}, 32'h41);
      #2 rst_n = 1'b0;
      #1;
      check("abort_we",   {31'h0, bus.mem_we},   32'h0);
      check("abort_busy", {31'h0, bus.busy},     32'h0);
      check("abort_addr", {24'h0, bus.mem_addr}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_m40", {24'h0, mem[8'h40]}, 32'h11);
      check("abort_m41", {24'h0, mem[8'h41]}, 32'h00);
      check("abort_m42", {24'h0, mem[8'h42]}, 32'h00);
      check("abort_m43", {24'h0, mem[8'h43]}, 32'h00);

      // normal transfer after abort
      load_plain();
      run_xfer(8'h10, 8'h40, 8'd4, 8'h00, 11, 1'b0);
      check_plain("post_abort");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
